// File: rtl/pong_game_ctrl_pkg.sv
// pong_game_ctrl_pkg: shared state codes, BCD width, display geometry and BCD increment helper.
package pong_game_ctrl_pkg;
    localparam int BCD_W = 4;
    localparam logic [1:0] ST_NEWGAME = 2'd0;
    localparam logic [1:0] ST_PLAY    = 2'd1;
    localparam logic [1:0] ST_NEWBALL = 2'd2;
    localparam logic [1:0] ST_OVER    = 2'd3;
    localparam int MAX_X  = 640;
    localparam int MAX_Y  = 480;
    localparam int REFR_Y = MAX_Y + 1;

    // Two-digit BCD increment, 99 wraps to 00.
    function automatic logic [2*BCD_W-1:0] bcd_inc(input logic [2*BCD_W-1:0] v);
        return (v[3:0] == 4'd9) ? {(v[7:4] == 4'd9) ? 4'd0 : v[7:4] + 4'd1, 4'd0}
                                : {v[7:4], v[3:0] + 4'd1};
    endfunction
endpackage

// File: rtl/pong_frame_timer.sv
// pong_frame_timer: frame-counting down-timer; start (re)loads, refr_tick decrements, done while zero.
module pong_frame_timer #(
    parameter int TIMER_FRAMES = 120
) (
    input  logic clk,
    input  logic reset_n,
    input  logic refr_tick,
    input  logic start,
    output logic done
);
    logic [6:0] count;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)
            count <= '0;
        else if (start)
            count <= 7'(TIMER_FRAMES);
        else if (refr_tick && count != '0)
            count <= count - 7'd1;

    assign done = (count == '0);
endmodule

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: pong game sequencer (new game / play / new ball / over), ball count and BCD score.
// Define PONG_HIGH_SCORE_EN to keep a BCD high score; otherwise hi_d1/hi_d0 read zero.
module pong_game_ctrl
    import pong_game_ctrl_pkg::*;
#(
    parameter int NUM_BALLS    = 3,
    parameter int TIMER_FRAMES = 120
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             refr_tick,
    input  logic [1:0]       btn,
    input  logic             hit,
    input  logic             miss,
    output logic             graph_still,
    output logic             game_over,
    output logic [1:0]       ball_cnt,
    output logic [BCD_W-1:0] score_d1,
    output logic [BCD_W-1:0] score_d0,
    output logic [BCD_W-1:0] hi_d1,
    output logic [BCD_W-1:0] hi_d0
);
    logic [1:0]         state, state_nxt;
    logic [2*BCD_W-1:0] score;
    logic               timer_done, timer_start, start_play;

    assign start_play  = (state == ST_NEWGAME) && (btn != 2'b00);
    assign timer_start = (state == ST_PLAY) && miss;

    pong_frame_timer #(.TIMER_FRAMES(TIMER_FRAMES)) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .refr_tick(refr_tick),
        .start    (timer_start),
        .done     (timer_done)
    );

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)
            state <= ST_NEWGAME;
        else
            state <= state_nxt;

    always_comb begin
        state_nxt = (state == ST_NEWGAME) ? (start_play ? ST_PLAY : ST_NEWGAME) :
                    (state == ST_PLAY)    ? (miss ? ((ball_cnt == 2'd0) ? ST_OVER : ST_NEWBALL) : ST_PLAY) :
                    (state == ST_NEWBALL) ? ((timer_done && btn != 2'b00) ? ST_PLAY : ST_NEWBALL) :
                                            (timer_done ? ST_NEWGAME : ST_OVER);
    end

    always_comb begin
        graph_still = (state != ST_PLAY);
        game_over   = (state == ST_OVER);
    end

    // Miss has priority over a same-cycle hit, so a final-ball score is never bumped.
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            ball_cnt <= 2'(NUM_BALLS);
            score    <= '0;
        end else begin
            if ((start_play || timer_start) && ball_cnt != 2'd0)
                ball_cnt <= ball_cnt - 2'd1;
            else if (state == ST_OVER && timer_done)
                ball_cnt <= 2'(NUM_BALLS);
            if (start_play)
                score <= '0;
            else if (state == ST_PLAY && hit && !miss)
                score <= bcd_inc(score);
        end

    assign {score_d1, score_d0} = score;

`ifdef PONG_HIGH_SCORE_EN
    logic [2*BCD_W-1:0] hi;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)
            hi <= '0;
        else if (timer_start && ball_cnt == 2'd0 && score > hi)
            hi <= score;

    assign {hi_d1, hi_d0} = hi;
`else
    assign hi_d1 = '0;
    assign hi_d0 = '0;
`endif
endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl: directed scoreboard bench for pong_game_ctrl (default NUM_BALLS=3, TIMER_FRAMES=120).
module tb_pong_game_ctrl;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       refr_tick = 1'b0;
    logic [1:0] btn = 2'b00;
    logic       hit = 1'b0;
    logic       miss = 1'b0;
    logic       graph_still, game_over;
    logic [1:0] ball_cnt;
    logic [3:0] score_d1, score_d0, hi_d1, hi_d0;

    int n_assert = 0;
    int n_fail = 0;

    logic       exp_gs, exp_go;
    logic [1:0] exp_bc;
    int         exp_sc, exp_hi;

    logic [19:0] exp_q[$];
    string       tag_q[$];

    pong_game_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .refr_tick  (refr_tick),
        .btn        (btn),
        .hit        (hit),
        .miss       (miss),
        .graph_still(graph_still),
        .game_over  (game_over),
        .ball_cnt   (ball_cnt),
        .score_d1   (score_d1),
        .score_d0   (score_d0),
        .hi_d1      (hi_d1),
        .hi_d0      (hi_d0)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] to_bcd(input int x);
        return {4'(x / 10), 4'(x % 10)};
    endfunction

    task automatic push(input string tag);
        exp_q.push_back({exp_gs, exp_go, exp_bc, to_bcd(exp_sc), to_bcd(exp_hi)});
        tag_q.push_back(tag);
    endtask

    task automatic chk();
        logic [19:0] obs, e;
        string t;
        obs = {graph_still, game_over, ball_cnt, score_d1, score_d0, hi_d1, hi_d0};
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        n_assert++;
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s: observed gs/go/bc/score/hi=%h required %h", t, obs, e);
        end
    endtask

    task automatic step(input logic [1:0] b, input logic h, input logic m, input logic r, input int n);
        repeat (n) begin
            btn = b; hit = h; miss = m; refr_tick = r;
            @(posedge clk);
            #1;
            hit = 1'b0; miss = 1'b0; refr_tick = 1'b0;
        end
    endtask

    task automatic hits(input int n);
        step(2'b00, 1'b1, 1'b0, 1'b0, n);
        exp_sc = (exp_sc + n) % 100;
    endtask

    initial begin
        exp_gs = 1'b1; exp_go = 1'b0; exp_bc = 2'd3; exp_sc = 0; exp_hi = 0;
        push("reset");
        step(2'b00, 1'b0, 1'b0, 1'b0, 2);
        chk();
        reset_n = 1'b1;

        push("start_game");
        step(2'b01, 1'b0, 1'b0, 1'b0, 1);
        exp_gs = 1'b0; exp_bc = 2'd2; exp_q[0] = {exp_gs, exp_go, exp_bc, to_bcd(exp_sc), to_bcd(exp_hi)};
        chk();

        hits(12); push("score_12"); chk();
        hits(87); push("score_99"); chk();
        hits(1);  push("wrap_99_00"); chk();
        hits(9);  push("score_09"); chk();
        hits(1);  push("carry_09_10"); chk();

        exp_gs = 1'b1; exp_bc = 2'd1;
        push("miss_newball");
        step(2'b01, 1'b0, 1'b1, 1'b0, 1);
        chk();
        push("hit_miss_ignored_newball");
        step(2'b01, 1'b1, 1'b1, 1'b0, 1);
        chk();
        step(2'b01, 1'b0, 1'b0, 1'b1, 119);
        push("newball_119_ticks"); chk();
        step(2'b01, 1'b0, 1'b0, 1'b1, 1);
        push("newball_120_ticks"); chk();
        exp_gs = 1'b0;
        step(2'b01, 1'b0, 1'b0, 1'b0, 1);
        push("play_after_done"); chk();

        hits(5);
        exp_gs = 1'b1; exp_bc = 2'd0;
        step(2'b00, 1'b0, 1'b1, 1'b0, 1);
        push("miss_last_newball"); chk();
        step(2'b10, 1'b0, 1'b0, 1'b1, 60);
        step(2'b00, 1'b0, 1'b0, 1'b1, 60);
        step(2'b00, 1'b0, 1'b0, 1'b0, 1);
        push("early_btn_not_latched"); chk();
        exp_gs = 1'b0;
        step(2'b10, 1'b0, 1'b0, 1'b0, 1);
        push("play_last_ball"); chk();

        exp_gs = 1'b1; exp_go = 1'b1;
`ifdef PONG_HIGH_SCORE_EN
        exp_hi = 15;
`endif
        step(2'b00, 1'b1, 1'b1, 1'b0, 1);
        push("over_miss_wins"); chk();
        step(2'b00, 1'b0, 1'b0, 1'b1, 120);
        push("over_120_ticks"); chk();
        exp_go = 1'b0; exp_bc = 2'd3;
        step(2'b00, 1'b0, 1'b0, 1'b0, 1);
        push("newgame_reload"); chk();

        exp_gs = 1'b0; exp_bc = 2'd2; exp_sc = 0;
        step(2'b11, 1'b0, 1'b0, 1'b0, 1);
        push("game2_start"); chk();
        hits(8);
        for (int b = 1; b >= 0; b--) begin
            step(2'b00, 1'b0, 1'b1, 1'b0, 1);
            step(2'b00, 1'b0, 1'b0, 1'b1, 120);
            step(2'b01, 1'b0, 1'b0, 1'b0, 1);
        end
        exp_bc = 2'd0;
        push("game2_last_ball"); chk();
        exp_gs = 1'b1; exp_go = 1'b1;
        step(2'b00, 1'b0, 1'b1, 1'b0, 1);
        push("game2_over_hi_kept"); chk();

        step(2'b00, 1'b0, 1'b0, 1'b1, 120);
        step(2'b00, 1'b0, 1'b0, 1'b0, 1);
        step(2'b01, 1'b0, 1'b0, 1'b0, 1);
        exp_gs = 1'b0; exp_go = 1'b0; exp_bc = 2'd2; exp_sc = 0;
        hits(7);
        push("game3_score_07"); chk();

        exp_gs = 1'b1; exp_bc = 2'd3; exp_sc = 0; exp_hi = 0;
        reset_n = 1'b0;
        #1;
        push("async_reset_midplay"); chk();
        step(2'b00, 1'b0, 1'b0, 1'b0, 1);
        push("reset_held"); chk();
        reset_n = 1'b1;
        exp_gs = 1'b0; exp_bc = 2'd2;
        step(2'b01, 1'b0, 1'b0, 1'b0, 1);
        push("restart_after_reset"); chk();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
